// File: rtl/fwd_hazard_sched.sv
`default_nettype none
// ============================================================================
// Module  : fwd_hazard_sched
// Purpose : Shadow-pipeline forwarding select and load-use stall generator.
// Revision: 1.0
// ============================================================================
module fwd_hazard_sched #(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_en,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [AW-1:0]    id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic             id_stall,
  output logic [SEL_W-1:0] ex_fwd_a,
  output logic [SEL_W-1:0] ex_fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  // Shadow entry per stage; index 1 is EX.
  logic          r_valid [1:DEPTH];
  logic [AW-1:0] r_dst   [1:DEPTH];
  logic          r_rw    [1:DEPTH];
  logic          r_ld    [1:DEPTH];

  logic [SEL_W-1:0] r_fwd_a;
  logic [SEL_W-1:0] r_fwd_b;
  logic [CNT_W-1:0] r_cnt;

  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;
  logic             w_haz_a;
  logic             w_haz_b;
  logic             w_accept;

  // Scan oldest-to-youngest so the youngest (smallest s) match overrides.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int s = DEPTH - 1; s >= 1; s--) begin
      if (id_valid && id_use_rs && r_valid[s] && r_rw[s] &&
          r_dst[s] == id_rs && id_rs != '0) begin
        w_sel_a = SEL_W'(s + 1);
        w_haz_a = r_ld[s] && ((s + 1) < LOAD_READY);
      end
      if (id_valid && id_use_rt && r_valid[s] && r_rw[s] &&
          r_dst[s] == id_rt && id_rt != '0) begin
        w_sel_b = SEL_W'(s + 1);
        w_haz_b = r_ld[s] && ((s + 1) < LOAD_READY);
      end
    end
  end

  assign id_stall = (w_haz_a || w_haz_b) && !flush;
  assign w_accept = !id_stall && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 1; s <= DEPTH; s++) begin
        r_valid[s] <= 1'b0;
        r_dst[s]   <= '0;
        r_rw[s]    <= 1'b0;
        r_ld[s]    <= 1'b0;
      end
      r_fwd_a <= '0;
      r_fwd_b <= '0;
      r_cnt   <= '0;
    end else if (pipe_en) begin
      for (int s = DEPTH; s >= 2; s--) begin
        r_valid[s] <= r_valid[s-1];
        r_dst[s]   <= r_dst[s-1];
        r_rw[s]    <= r_rw[s-1];
        r_ld[s]    <= r_ld[s-1];
      end
      r_valid[1] <= w_accept && id_valid;
      r_dst[1]   <= id_dst;
      r_rw[1]    <= id_regwrite;
      r_ld[1]    <= id_memread;
      r_fwd_a    <= w_accept ? w_sel_a : '0;
      r_fwd_b    <= w_accept ? w_sel_b : '0;
      if (id_stall && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_fwd_a    = r_fwd_a;
  assign ex_fwd_b    = r_fwd_b;
  assign stall_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_sched.sv
`default_nettype none
// Directed bench for fwd_hazard_sched (DEPTH=3, LOAD_READY=3) plus a CNT_W=2 copy.
module tb_fwd_hazard_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       pipe_en;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_dst;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_stall;
  logic [1:0] ex_fwd_a;
  logic [1:0] ex_fwd_b;
  logic [15:0] stall_count;
  logic       id_stall2;
  logic [1:0] ex_fwd_a2;
  logic [1:0] ex_fwd_b2;
  logic [1:0] stall_count2;

  int tests = 0;
  int fails = 0;

  fwd_hazard_sched #(.AW(5), .DEPTH(3), .LOAD_READY(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .pipe_en(pipe_en), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_stall(id_stall), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .stall_count(stall_count)
  );

  fwd_hazard_sched #(.AW(5), .DEPTH(3), .LOAD_READY(3), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .pipe_en(pipe_en), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_stall(id_stall2), .ex_fwd_a(ex_fwd_a2), .ex_fwd_b(ex_fwd_b2),
    .stall_count(stall_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_dst      = dst;
    id_regwrite = rw;
    id_memread  = mr;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    reset   = 1'b1;
    pipe_en = 1'b1;
    flush   = 1'b0;
    nop();
    #11;
    chk("reset_stall", int'(id_stall), 0);
    chk("reset_fwd_a", int'(ex_fwd_a), 0);
    chk("reset_fwd_b", int'(ex_fwd_b), 0);
    chk("reset_count", int'(stall_count), 0);
    reset = 1'b0;
    tick();

    // add $8 then dependent add one cycle later
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    chk("add8_stall", int'(id_stall), 0);
    tick();
    chk("add8_fwd_a", int'(ex_fwd_a), 0);
    set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    chk("dist1_stall", int'(id_stall), 0);
    tick();
    chk("dist1_fwd_a", int'(ex_fwd_a), 2);
    chk("dist1_fwd_b", int'(ex_fwd_b), 0);

    // gap of one bubble: rt=$10 at distance 2, rs=$8 at distance 3
    nop();
    tick();
    set_id(1'b1, 5'd8, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tick();
    chk("dist3_fwd_a", int'(ex_fwd_a), 0);
    chk("dist2_fwd_b", int'(ex_fwd_b), 3);
    drain();

    // load-use: one stall cycle, bubble, then forward from stage 3
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
    chk("lu_stall_on", int'(id_stall), 1);
    tick();
    chk("lu_bubble_fwd_a", int'(ex_fwd_a), 0);
    chk("lu_count1", int'(stall_count), 1);
    chk("lu_stall_off", int'(id_stall), 0);
    tick();
    chk("lu_fwd_a", int'(ex_fwd_a), 3);
    chk("lu_count_hold", int'(stall_count), 1);
    drain();

    // two writers of $8: youngest wins; unused operand; $0 never matches
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);
    tick();
    chk("youngest_fwd_a", int'(ex_fwd_a), 2);
    set_id(1'b1, 5'd8, 5'd8, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0);
    tick();
    chk("unused_rs_fwd_a", int'(ex_fwd_a), 0);
    chk("used_rt_fwd_b", int'(ex_fwd_b), 3);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
    chk("r0_stall", int'(id_stall), 0);
    tick();
    chk("r0_fwd_a", int'(ex_fwd_a), 0);
    chk("r0_fwd_b", int'(ex_fwd_b), 0);
    drain();

    // freeze with pipe_en=0 during a stall, then flush wins
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    chk("lw_base_fwd_a", int'(ex_fwd_a), 2);
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
    chk("frz_stall_pre", int'(id_stall), 1);
    pipe_en = 1'b0;
    repeat (4) tick();
    chk("frz_stall", int'(id_stall), 1);
    chk("frz_fwd_a", int'(ex_fwd_a), 2);
    chk("frz_count", int'(stall_count), 1);
    pipe_en = 1'b1;
    flush   = 1'b1;
    #1;
    chk("flush_stall", int'(id_stall), 0);
    tick();
    flush = 1'b0;
    chk("flush_count", int'(stall_count), 1);
    chk("flush_fwd_a", int'(ex_fwd_a), 0);
    drain();

    // four more stalls: 5 total, 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0);
      tick();
    end
    chk("sat_count16", int'(stall_count), 5);
    chk("sat_count2", int'(stall_count2), 3);

    // reset while a stall is pending clears everything immediately
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    chk("pre_rst_fwd_a", int'(ex_fwd_a), 3);
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
    chk("pre_rst_stall", int'(id_stall), 1);
    reset = 1'b1;
    #1;
    chk("rst_stall", int'(id_stall), 0);
    chk("rst_fwd_a", int'(ex_fwd_a), 0);
    chk("rst_count", int'(stall_count), 0);
    chk("rst_count2", int'(stall_count2), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_stall", int'(id_stall), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
